// File: rtl/prbs7_checker.sv
// Receive-side checker for the x^7+x^6+1 word-wide PRBS stream: hunts for a seed,
// verifies a run of predictions, then flywheels and counts mismatches while locked.
module prbs7_checker #(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int ERR_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [6:0]       in_word,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic             period_done
);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
  localparam logic [3:0] LOSS_N = 4'(LOSS_COUNT);

  state_t     state;
  logic [6:0] expected;
  logic [3:0] good_cnt;
  logic [3:0] bad_cnt;
  logic [6:0] period_cnt;
  logic       match;
  logic       err_inc;

  function automatic logic [6:0] next_word(input logic [6:0] w);
    return {w[5:0], w[6] ^ w[5]};
  endfunction

  assign match   = (in_word == expected);
  assign err_inc = in_valid && (state == LOCKED) && !match;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= HUNT;
      expected    <= '0;
      good_cnt    <= '0;
      bad_cnt     <= '0;
      period_cnt  <= '0;
      locked      <= 1'b0;
      err_pulse   <= 1'b0;
      period_done <= 1'b0;
    end else begin
      err_pulse   <= 1'b0;
      period_done <= 1'b0;
      if (in_valid) begin
        case (state)
          HUNT: begin
            if (in_word != 7'd0) begin
              expected <= next_word(in_word);
              good_cnt <= '0;
              state    <= VERIFY;
            end
          end
          VERIFY: begin
            if (match) begin
              expected <= next_word(in_word);
              good_cnt <= good_cnt + 4'd1;
              if (good_cnt + 4'd1 == LOCK_N) begin
                state      <= LOCKED;
                locked     <= 1'b1;
                bad_cnt    <= '0;
                period_cnt <= '0;
              end
            end else if (in_word != 7'd0) begin
              expected <= next_word(in_word);
              good_cnt <= '0;
            end else begin
              state <= HUNT;
            end
          end
          LOCKED: begin
            // Flywheel: once locked the prediction never follows the received data.
            expected <= next_word(expected);
            if (period_cnt == 7'd126) begin
              period_cnt  <= '0;
              period_done <= 1'b1;
            end else begin
              period_cnt <= period_cnt + 7'd1;
            end
            if (match) begin
              bad_cnt <= '0;
            end else begin
              err_pulse <= 1'b1;
              if (bad_cnt + 4'd1 == LOSS_N) begin
                state    <= HUNT;
                locked   <= 1'b0;
                bad_cnt  <= '0;
                good_cnt <= '0;
              end else begin
                bad_cnt <= bad_cnt + 4'd1;
              end
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

  // Clear wins over a same-cycle increment; the count survives loss of lock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (clr) begin
      err_count <= '0;
    end else if (err_inc && (err_count != '1)) begin
      err_count <= err_count + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_prbs7_checker.sv
// Bench for prbs7_checker: a default instance and a 4-bit-counter instance share
// one stimulus stream and are checked every cycle against a sequence-index model.
module tb_prbs7_checker;

  localparam int LOCK_COUNT = 4;
  localparam int LOSS_COUNT = 3;
  localparam int M_HUNT   = 0;
  localparam int M_VERIFY = 1;
  localparam int M_LOCKED = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [6:0]  in_word = 7'd0;
  logic        locked, err_pulse, period_done;
  logic [15:0] err_count;
  logic        s_locked, s_err_pulse, s_period_done;
  logic [3:0]  s_err_count;

  int vectors = 0;
  int miscompares = 0;
  string phase = "reset";

  // Reference: the whole 127-word sequence and each word's position in it.
  int seq [127];
  int idx_of [128];
  int m_mode, m_pos, m_run, m_miss, m_words, m_total, m_dones, dut_dones;
  logic m_pulse, m_done;

  prbs7_checker #(.LOCK_COUNT(LOCK_COUNT), .LOSS_COUNT(LOSS_COUNT), .ERR_W(16)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_word(in_word),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .period_done(period_done)
  );

  prbs7_checker #(.LOCK_COUNT(LOCK_COUNT), .LOSS_COUNT(LOSS_COUNT), .ERR_W(4)) dut_small (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_word(in_word),
    .locked(s_locked), .err_pulse(s_err_pulse), .err_count(s_err_count),
    .period_done(s_period_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (period_done) dut_dones <= dut_dones + 1;

  function automatic int sat(input int total, input int max_val);
    return (total > max_val) ? max_val : total;
  endfunction

  function automatic logic [6:0] predicted();
    return 7'(seq[m_pos]);
  endfunction

  task automatic model_reset();
    m_mode = M_HUNT; m_pos = 0; m_run = 0; m_miss = 0; m_words = 0;
    m_total = 0; m_pulse = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_edge(input logic v, input logic [6:0] w, input logic c);
    int wi;
    wi = int'(w);
    m_pulse = 1'b0;
    m_done  = 1'b0;
    if (v) begin
      case (m_mode)
        M_HUNT: if (wi != 0) begin
          m_pos = (idx_of[wi] + 1) % 127; m_run = 0; m_mode = M_VERIFY;
        end
        M_VERIFY: begin
          if (wi == seq[m_pos]) begin
            m_run++;
            m_pos = (m_pos + 1) % 127;
            if (m_run == LOCK_COUNT) begin
              m_mode = M_LOCKED; m_miss = 0; m_words = 0;
            end
          end else if (wi != 0) begin
            m_pos = (idx_of[wi] + 1) % 127; m_run = 0;
          end else begin
            m_mode = M_HUNT;
          end
        end
        default: begin
          m_words++;
          if (m_words % 127 == 0) begin m_done = 1'b1; m_dones++; end
          if (wi != seq[m_pos]) begin
            m_pulse = 1'b1; m_total++; m_miss++;
            if (m_miss == LOSS_COUNT) m_mode = M_HUNT;
          end else begin
            m_miss = 0;
          end
          m_pos = (m_pos + 1) % 127;
        end
      endcase
    end
    if (c) m_total = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s [%s] observed=%0h expected=%0h", tag, phase, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("locked", 32'(locked), 32'(m_mode == M_LOCKED));
    chk("err_pulse", 32'(err_pulse), 32'(m_pulse));
    chk("period_done", 32'(period_done), 32'(m_done));
    chk("err_count", 32'(err_count), 32'(sat(m_total, 65535)));
    chk("small.err_count", 32'(s_err_count), 32'(sat(m_total, 15)));
    chk("small.locked", 32'(s_locked), 32'(m_mode == M_LOCKED));
  endtask

  task automatic apply_step(input logic v, input logic [6:0] w, input logic c);
    in_valid = v; in_word = w; clr = c;
    @(posedge clk);
    model_edge(v, w, c);
    #1;
    check_outputs();
  endtask

  task automatic mismatch_word(output logic [6:0] w);
    w = predicted() ^ 7'($urandom_range(1, 127));
  endtask

  initial begin
    logic [6:0] w;
    int pos;
    seq[0] = 1;
    for (int i = 1; i < 127; i++)
      seq[i] = ((seq[i-1] * 2) & 126) | (((seq[i-1] >> 6) ^ (seq[i-1] >> 5)) & 1);
    for (int i = 0; i < 127; i++) idx_of[seq[i]] = i;
    idx_of[0] = 0;
    model_reset();
    m_dones = 0;
    dut_dones = 0;

    phase = "reset";
    @(posedge clk); @(posedge clk); #1;
    check_outputs();
    rst = 1'b0;

    phase = "acquire";
    apply_step(1'b1, 7'h01, 1'b0);
    apply_step(1'b1, 7'h02, 1'b0);
    apply_step(1'b1, 7'h04, 1'b0);
    apply_step(1'b1, 7'h08, 1'b0);
    apply_step(1'b1, 7'h10, 1'b0);

    phase = "single_err";
    apply_step(1'b1, 7'h00, 1'b0);
    apply_step(1'b1, 7'h41, 1'b0);
    apply_step(1'b1, 7'h03, 1'b0);

    phase = "loss";
    for (int i = 0; i < 3; i++) apply_step(1'b1, 7'h7F, 1'b0);
    phase = "relock";
    pos = idx_of[7'h30];
    for (int i = 0; i < LOCK_COUNT + 2; i++) apply_step(1'b1, 7'(seq[(pos + i) % 127]), 1'b0);

    phase = "gaps_period";
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) apply_step(1'b1, predicted(), 1'b0);
      else apply_step(1'b0, 7'($urandom_range(0, 127)), 1'b0);
    end
    phase = "period_total";
    chk("period_pulses", 32'(dut_dones), 32'(m_dones));

    phase = "hunt_zero";
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) apply_step(1'b1, 7'h00, 1'b0);
    phase = "verify_reseed";
    apply_step(1'b1, 7'h01, 1'b0);
    apply_step(1'b1, 7'h02, 1'b0);
    apply_step(1'b1, 7'h05, 1'b0);
    pos = idx_of[7'h05];
    for (int i = 1; i <= LOCK_COUNT + 1; i++) apply_step(1'b1, 7'(seq[(pos + i) % 127]), 1'b0);

    phase = "saturate";
    for (int i = 0; i < 20; i++) begin
      mismatch_word(w);
      apply_step(1'b1, w, 1'b0);
      apply_step(1'b1, predicted(), 1'b0);
    end

    phase = "clr_collide";
    mismatch_word(w);
    apply_step(1'b1, w, 1'b1);
    apply_step(1'b1, predicted(), 1'b0);

    phase = "random_link";
    pos = 17;
    for (int i = 0; i < 300; i++) begin
      w = 7'(seq[pos % 127]);
      if ($urandom_range(0, 11) == 0) w = w ^ 7'($urandom_range(1, 127));
      if ($urandom_range(0, 4) != 0) begin
        apply_step(1'b1, w, 1'($urandom_range(0, 40) == 0));
        pos++;
      end else begin
        apply_step(1'b0, w, 1'b0);
      end
    end

    phase = "async_reset";
    pos = idx_of[7'h01];
    for (int i = 0; i < LOCK_COUNT + 3; i++) apply_step(1'b1, 7'(seq[(pos + i) % 127]), 1'b0);
    mismatch_word(w);
    apply_step(1'b1, w, 1'b0);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check_outputs();
    @(posedge clk); #1;
    rst = 1'b0;
    check_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
